// File: rtl/mem_line_responder_pkg.sv
// Shared constants for the cache-side main-memory responder: defaults, FSM
// encodings and address-split helpers.
package mem_line_responder_pkg;

    localparam int MEM_WORD_SIZE  = 32;
    localparam int MEM_LINE_WORDS = 4;
    localparam int MEM_LATENCY    = 5;

    localparam logic [1:0] MEM_IDLE = 2'd0;
    localparam logic [1:0] MEM_BUSY = 2'd1;
    localparam logic [1:0] MEM_RESP = 2'd2;

    // Byte-offset bits inside one line.
    function automatic int lineOffBits(input int wordSize, input int lineWords);
        return $clog2(lineWords * wordSize / 8);
    endfunction

    function automatic int lineIdxBits(input int depthLines);
        return $clog2(depthLines);
    endfunction

endpackage

// File: rtl/mem_line_responder_array.sv
// Line storage for the responder: one synchronous write port and one
// registered read port whose output register can be cleared.
module mem_line_array
    import mem_line_responder_pkg::*;
#(
    parameter int  LINE_BITS   = 128,
    parameter int  DEPTH_LINES = 1024,
    localparam int IDX         = lineIdxBits(DEPTH_LINES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [IDX-1:0]       widx,
    input  logic [LINE_BITS-1:0] wdata,
    input  logic                 re,
    input  logic                 rclr,
    input  logic [IDX-1:0]       ridx,
    output logic [LINE_BITS-1:0] rdata
);

    logic [LINE_BITS-1:0] lines [DEPTH_LINES];

    always_ff @(posedge clk) begin
        if (we) begin
            lines[widx] <= wdata;
        end
    end

    // The read register doubles as the response data register, so it is
    // reset and cleared for write responses; the storage itself is not reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (rclr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= lines[ridx];
        end
    end

endmodule

// File: rtl/mem_line_responder.sv
// Main-memory responder for data-cache line fills and writebacks: one request
// at a time, fixed access latency, registered response handshake.
module mem_line_responder
    import mem_line_responder_pkg::*;
#(
    parameter int  WORD_SIZE   = MEM_WORD_SIZE,
    parameter int  LINE_WORDS  = MEM_LINE_WORDS,
    parameter int  DEPTH_LINES = 1024,
    parameter int  LATENCY     = MEM_LATENCY,
    localparam int LINE_BITS   = WORD_SIZE * LINE_WORDS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ReqValid,
    output logic                 ReqReady,
    input  logic                 ReqWrite,
    input  logic [WORD_SIZE-1:0] ReqAddr,
    input  logic [LINE_BITS-1:0] ReqWData,
    output logic                 RespValid,
    input  logic                 RespReady,
    output logic                 RespWrite,
    output logic [LINE_BITS-1:0] RespRData
);

    localparam int OFF = lineOffBits(WORD_SIZE, LINE_WORDS);
    localparam int IDX = lineIdxBits(DEPTH_LINES);
    localparam int CW  = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam bit DIRECT = (LATENCY == 1);

    logic [1:0]           stateReg;
    logic [CW-1:0]        counterReg;
    logic                 reqWriteReg;
    logic [IDX-1:0]       reqIdxReg;
    logic [LINE_BITS-1:0] reqWDataReg;

    logic [IDX-1:0]       reqIdx;
    logic                 accept;
    logic                 commitBusy;
    logic                 commit;
    logic                 commitWrite;
    logic [IDX-1:0]       arrIdx;
    logic [LINE_BITS-1:0] arrWData;
    logic                 arrWe;
    logic                 arrRe;
    logic                 unusedAddrBits;

    assign reqIdx         = ReqAddr[OFF +: IDX];
    assign unusedAddrBits = ^{ReqAddr[WORD_SIZE-1:OFF+IDX], ReqAddr[OFF-1:0]};

    assign accept     = (stateReg == MEM_IDLE) && ReqValid && ReqReady;
    assign commitBusy = (stateReg == MEM_BUSY) && (counterReg == CNT_ONE);

    // With a one-cycle latency the array is accessed straight from the request
    // inputs on the accepting edge; otherwise from the latched request.
    always_comb begin
        commit      = commitBusy;
        commitWrite = reqWriteReg;
        arrIdx      = reqIdxReg;
        arrWData    = reqWDataReg;
        if (DIRECT && accept) begin
            commit      = 1'b1;
            commitWrite = ReqWrite;
            arrIdx      = reqIdx;
            arrWData    = ReqWData;
        end
    end

    assign arrWe = commit && commitWrite;
    assign arrRe = commit && !commitWrite;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg    <= MEM_IDLE;
            counterReg  <= '0;
            ReqReady    <= 1'b0;
            RespValid   <= 1'b0;
            RespWrite   <= 1'b0;
            reqWriteReg <= 1'b0;
            reqIdxReg   <= '0;
            reqWDataReg <= '0;
        end else begin
            case (stateReg)
                MEM_IDLE: begin
                    if (accept) begin
                        reqWriteReg <= ReqWrite;
                        reqIdxReg   <= reqIdx;
                        reqWDataReg <= ReqWData;
                        counterReg  <= CNT_LOAD;
                        ReqReady    <= 1'b0;
                        if (DIRECT) begin
                            stateReg  <= MEM_RESP;
                            RespValid <= 1'b1;
                            RespWrite <= ReqWrite;
                        end else begin
                            stateReg <= MEM_BUSY;
                        end
                    end else begin
                        ReqReady <= 1'b1;
                    end
                end
                MEM_BUSY: begin
                    counterReg <= counterReg - CNT_ONE;
                    if (commitBusy) begin
                        stateReg  <= MEM_RESP;
                        RespValid <= 1'b1;
                        RespWrite <= reqWriteReg;
                    end
                end
                MEM_RESP: begin
                    if (RespReady) begin
                        RespValid <= 1'b0;
                        ReqReady  <= 1'b1;
                        stateReg  <= MEM_IDLE;
                    end
                end
                default: begin
                    stateReg <= MEM_IDLE;
                end
            endcase
        end
    end

    mem_line_array #(
        .LINE_BITS  (LINE_BITS),
        .DEPTH_LINES(DEPTH_LINES)
    ) lineArray (
        .clk  (clk),
        .rst  (rst),
        .we   (arrWe),
        .widx (arrIdx),
        .wdata(arrWData),
        .re   (arrRe),
        .rclr (arrWe),
        .ridx (arrIdx),
        .rdata(RespRData)
    );

endmodule
